// File: rtl/cp0_timer_exc_if.sv
// Pipeline <-> CP0 bus: mtc0/mfc0 access, exception/interrupt reporting, eret and redirect.
// The pipeline side is the master, CP0 is the slave.
interface cp0_timer_exc_if #(
  parameter int N_HWINT = 5
) ();
  logic               we;
  logic [4:0]         r_reg;
  logic [31:0]        data_in;
  logic [31:0]        data_out;
  logic               exc_valid;
  logic [4:0]         exc_code;
  logic [31:0]        exc_pc;
  logic               exc_bd;
  logic [31:0]        exc_badvaddr;
  logic [31:0]        int_pc;
  logic               int_bd;
  logic               int_pc_valid;
  logic               eret;
  logic [N_HWINT-1:0] int_;
  logic               INT;
  logic               exc_take;
  logic [31:0]        exc_vector;
  logic [31:0]        eret_pc;
  logic [31:0]        STATUS_out;
  logic [31:0]        CAUSE_out;
  logic [31:0]        EPC_out;

  modport master (
    output we, r_reg, data_in, exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr,
           int_pc, int_bd, int_pc_valid, eret, int_,
    input  data_out, INT, exc_take, exc_vector, eret_pc, STATUS_out, CAUSE_out, EPC_out
  );

  modport slave (
    input  we, r_reg, data_in, exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr,
           int_pc, int_bd, int_pc_valid, eret, int_,
    output data_out, INT, exc_take, exc_vector, eret_pc, STATUS_out, CAUSE_out, EPC_out
  );
endinterface

// File: rtl/cp0_timer_exc.sv
// MIPS coprocessor 0: Count/Compare timer, Status/Cause/EPC/BadVAddr, interrupt
// synchronisation and exception-over-interrupt prioritisation with redirect vector.
module cp0_timer_exc #(
  parameter int          N_HWINT     = 5,
  parameter int          TIMER_DIV   = 2,
  parameter logic [31:0] EXC_BASE    = 32'h8000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  cp0_timer_exc_if.slave bus
);
  localparam logic [7:0] PRESCALE_LAST = 8'(TIMER_DIV - 1);

  logic [31:0]        r_status;
  logic               r_cause_bd;
  logic               r_ip7;
  logic [4:0]         r_ip_hw;
  logic [1:0]         r_sw_ip;
  logic [4:0]         r_exc_code;
  logic [31:0]        r_epc;
  logic [31:0]        r_badvaddr;
  logic [31:0]        r_count;
  logic [31:0]        r_compare;
  logic [7:0]         r_prescale;
  logic               r_match;
  logic [N_HWINT-1:0] r_sync [SYNC_STAGES];

  logic        w_ie, w_exl, w_erl, w_bev, w_cause_iv;
  logic [7:0]  w_im, w_ip;
  logic [31:0] w_cause;
  logic        w_int, w_is_int, w_take, w_eret, w_tick, w_ev_bd;
  logic [31:0] w_ev_pc, w_count_inc, w_rdata;
  logic [4:0]  w_sync_ext;
  logic        w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;

  assign w_ie   = r_status[0];
  assign w_exl  = r_status[1];
  assign w_erl  = r_status[2];
  assign w_im   = r_status[15:8];
  assign w_bev  = r_status[22];
  // IV is not writable by mtc0 and no hardware event sets it, so it reads 0.
  assign w_cause_iv = 1'b0;

  assign w_ip    = {r_ip7, r_ip_hw, r_sw_ip};
  assign w_cause = {r_cause_bd, 7'b0, w_cause_iv, 7'b0, w_ip, 1'b0, r_exc_code, 2'b00};

  assign w_int    = (|(w_ip & w_im)) & w_ie & ~w_exl & ~w_erl;
  assign w_is_int = ~bus.exc_valid & w_int & bus.int_pc_valid;
  assign w_take   = bus.exc_valid | w_is_int;
  assign w_eret   = bus.eret & ~w_take;
  assign w_ev_pc  = bus.exc_valid ? bus.exc_pc : bus.int_pc;
  assign w_ev_bd  = bus.exc_valid ? bus.exc_bd : bus.int_bd;

  assign w_tick      = (r_prescale == PRESCALE_LAST);
  assign w_count_inc = r_count + 32'd1;
  assign w_sync_ext  = 5'(r_sync[SYNC_STAGES-1]);

  assign w_wr_count   = bus.we && (bus.r_reg == 5'd9);
  assign w_wr_compare = bus.we && (bus.r_reg == 5'd11);
  assign w_wr_status  = bus.we && (bus.r_reg == 5'd12);
  assign w_wr_cause   = bus.we && (bus.r_reg == 5'd13);
  assign w_wr_epc     = bus.we && (bus.r_reg == 5'd14);

  // NOTE: w_rdata gets a default before the case so no latch is inferred for unmapped numbers.
  always_comb begin
    w_rdata = '0;
    case (bus.r_reg)
      5'd8:    w_rdata = r_badvaddr;
      5'd9:    w_rdata = r_count;
      5'd11:   w_rdata = r_compare;
      5'd12:   w_rdata = r_status;
      5'd13:   w_rdata = w_cause;
      5'd14:   w_rdata = r_epc;
      default: w_rdata = '0;
    endcase
  end

  assign bus.data_out   = w_rdata;
  assign bus.INT        = w_int;
  assign bus.exc_take   = w_take;
  assign bus.exc_vector = w_bev                     ? 32'hBFC0_0380 :
                          (w_is_int && w_cause_iv)  ? EXC_BASE + 32'h200 :
                                                      EXC_BASE + 32'h180;
  assign bus.eret_pc    = r_epc;
  assign bus.STATUS_out = r_status;
  assign bus.CAUSE_out  = w_cause;
  assign bus.EPC_out    = r_epc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= 32'h0040_0004;
      r_cause_bd <= 1'b0;
      r_ip7      <= 1'b0;
      r_ip_hw    <= '0;
      r_sw_ip    <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_count    <= '0;
      r_compare  <= 32'hFFFF_FFFF;
      r_prescale <= '0;
      r_match    <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= bus.int_;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_ip_hw <= w_sync_ext;

      // A match is flagged on the incrementing edge and lands in IP7 one edge later.
      r_match <= w_tick && !w_wr_count && (w_count_inc == r_compare);
      if (w_wr_count) begin
        r_count    <= bus.data_in;
        r_prescale <= '0;
      end else if (w_tick) begin
        r_count    <= w_count_inc;
        r_prescale <= '0;
      end else begin
        r_prescale <= r_prescale + 8'd1;
      end

      if (w_wr_compare) r_compare <= bus.data_in;
      if (r_match)           r_ip7 <= 1'b1;
      else if (w_wr_compare) r_ip7 <= 1'b0;

      // NOTE: the hardware updates below are written after the mtc0 loads; of two
      // non-blocking assignments to the same bit in one block, the later one wins.
      if (w_wr_status) r_status   <= bus.data_in;
      if (w_wr_cause)  r_sw_ip    <= bus.data_in[9:8];
      if (w_wr_epc)    r_epc      <= bus.data_in;

      if (w_take) begin
        r_status[1] <= 1'b1;
        r_exc_code  <= w_is_int ? 5'd0 : bus.exc_code;
        if (!w_exl) begin
          r_epc      <= w_ev_bd ? w_ev_pc - 32'd4 : w_ev_pc;
          r_cause_bd <= w_ev_bd;
        end
        if (bus.exc_valid && (bus.exc_code == 5'd4 || bus.exc_code == 5'd5))
          r_badvaddr <= bus.exc_badvaddr;
      end else if (w_eret) begin
        if (w_erl) r_status[2] <= 1'b0;
        else       r_status[1] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cp0_timer_exc.sv
// Directed bench for cp0_timer_exc: stimulus pushes expected reads/redirects into
// queues, a negedge monitor pops and compares whenever a read strobe or exc_take is seen.
module tb_cp0_timer_exc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_strobe = 1'b0;

  always #5 clk = ~clk;

  cp0_timer_exc_if #(.N_HWINT(5)) bus ();
  cp0_timer_exc dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    int          sel;    // 0 data_out, 1 INT, 2 eret_pc
    logic [31:0] mask;
    logic [31:0] exp;
  } rd_item_t;

  typedef struct {
    string       name;
    logic [31:0] vec;
  } ev_item_t;

  rd_item_t rd_q[$];
  ev_item_t ev_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  rd_item_t m_rd;
  ev_item_t m_ev;
  logic [31:0] m_act;

  always @(negedge clk) begin
    if (rd_strobe) begin
      if (rd_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL read_strobe: no expected value queued");
      end else begin
        m_rd = rd_q.pop_front();
        case (m_rd.sel)
          1:       m_act = {31'b0, bus.INT};
          2:       m_act = bus.eret_pc;
          default: m_act = bus.data_out;
        endcase
        check(m_rd.name, m_act & m_rd.mask, m_rd.exp & m_rd.mask);
      end
    end
    if (bus.exc_take) begin
      if (ev_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_take: exc_take=1 vector %h", bus.exc_vector);
      end else begin
        m_ev = ev_q.pop_front();
        check(m_ev.name, bus.exc_vector, m_ev.vec);
      end
    end
  end

  task automatic rd(input string name, input logic [4:0] rn, input logic [31:0] exp,
                    input logic [31:0] mask = 32'hFFFF_FFFF);
    bus.r_reg = rn;
    rd_q.push_back('{name: name, sel: 0, mask: mask, exp: exp});
    rd_strobe = 1'b1;
    @(posedge clk); #1;
    rd_strobe = 1'b0;
  endtask

  task automatic rd_int(input string name, input logic exp);
    rd_q.push_back('{name: name, sel: 1, mask: 32'h1, exp: {31'b0, exp}});
    rd_strobe = 1'b1;
    @(posedge clk); #1;
    rd_strobe = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] rn, input logic [31:0] d);
    bus.we = 1'b1; bus.r_reg = rn; bus.data_in = d;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic do_eret(input string name, input logic [31:0] exp_pc);
    bus.eret = 1'b1;
    rd_q.push_back('{name: name, sel: 2, mask: 32'hFFFF_FFFF, exp: exp_pc});
    rd_strobe = 1'b1;
    @(posedge clk); #1;
    bus.eret = 1'b0; rd_strobe = 1'b0;
  endtask

  task automatic do_exc(input string name, input logic [4:0] code, input logic [31:0] pc,
                        input logic bd, input logic [31:0] bva, input logic [31:0] vec);
    ev_q.push_back('{name: name, vec: vec});
    bus.exc_valid = 1'b1; bus.exc_code = code; bus.exc_pc = pc;
    bus.exc_bd = bd; bus.exc_badvaddr = bva;
    @(posedge clk); #1;
    bus.exc_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.we = 0; bus.r_reg = 0; bus.data_in = 0;
    bus.exc_valid = 0; bus.exc_code = 0; bus.exc_pc = 0; bus.exc_bd = 0; bus.exc_badvaddr = 0;
    bus.int_pc = 0; bus.int_bd = 0; bus.int_pc_valid = 0; bus.eret = 0; bus.int_ = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    rd("rst_count", 5'd9, 32'h0);
    rd("rst_compare", 5'd11, 32'hFFFF_FFFF);
    rd("rst_status", 5'd12, 32'h0040_0004);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd_int("rst_int", 1'b0);

    mtc0(5'd12, 32'h0000_0001);
    rd("status_ie", 5'd12, 32'h0000_0001);
    rd("compare_ff", 5'd11, 32'hFFFF_FFFF);
    rd("epc_zero", 5'd14, 32'h0);
    rd("unmapped_10", 5'd10, 32'h0);

    // Timer: Count<-0, Compare<-5, IP7 after the fifth increment
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'h5);
    n = 0;
    while (!bus.CAUSE_out[15] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("ip7_latency_10_or_11", {31'b0, (n == 10 || n == 11)}, 32'h1);
    rd("count_at_match", 5'd9, 32'h5);
    mtc0(5'd12, 32'h0000_8001);
    rd_int("timer_int", 1'b1);
    rd("ip7_set", 5'd13, 32'h0000_8000, 32'h0000_8000);
    mtc0(5'd11, 32'hFFFF_FFFF);
    rd("ip7_cleared", 5'd13, 32'h0, 32'h0000_8000);
    rd_int("timer_int_clr", 1'b0);

    // Hardware interrupt on int_[0] in a delay slot
    mtc0(5'd12, 32'h0000_0401);
    bus.int_pc = 32'h0000_1004; bus.int_bd = 1'b1; bus.int_pc_valid = 1'b1;
    ev_q.push_back('{name: "hwint_vector", vec: 32'h8000_0180});
    bus.int_[0] = 1'b1;
    n = 0;
    while (!bus.exc_take && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("hwint_latency", 32'(n), 32'd3);
    @(posedge clk); #1;
    bus.int_pc_valid = 1'b0; bus.int_bd = 1'b0; bus.int_[0] = 1'b0;
    rd("hwint_epc", 5'd14, 32'h0000_1000);
    rd("hwint_cause", 5'd13, 32'h8000_0000, 32'h8000_007C);
    rd("hwint_status", 5'd12, 32'h0000_0003, 32'h0000_0007);
    rd_int("hwint_masked", 1'b0);
    repeat (4) @(posedge clk);
    #1;
    do_eret("eret_pc_1", 32'h0000_1000);
    rd("eret_exl_clr", 5'd12, 32'h0000_0001, 32'h0000_0007);

    // Exception beats a pending software interrupt in the same cycle
    mtc0(5'd13, 32'h0000_0100);
    mtc0(5'd12, 32'h0000_0101);
    rd_int("swint_pending", 1'b1);
    bus.int_pc = 32'h0000_5000; bus.int_pc_valid = 1'b1;
    do_exc("ov_vector", 5'd12, 32'h0000_2000, 1'b0, 32'hDEAD_BEEF, 32'h8000_0180);
    rd_int("int_masked_after_ov", 1'b0);
    bus.int_pc_valid = 1'b0;
    rd("ov_code", 5'd13, 32'h0000_0030, 32'h0000_007C);
    rd("ov_epc", 5'd14, 32'h0000_2000);
    rd("ov_badvaddr_kept", 5'd8, 32'h0);

    // Nested AdEL while EXL=1
    do_exc("adel_vector", 5'd4, 32'h0000_4000, 1'b0, 32'h0000_0003, 32'h8000_0180);
    rd("nested_epc_kept", 5'd14, 32'h0000_2000);
    rd("adel_badvaddr", 5'd8, 32'h0000_0003);
    rd("adel_code", 5'd13, 32'h0000_0010, 32'h0000_007C);
    do_eret("eret_pc_2", 32'h0000_2000);
    rd("eret2_exl_clr", 5'd12, 32'h0000_0101);

    // mtc0 Cause colliding with a syscall
    bus.we = 1'b1; bus.r_reg = 5'd13; bus.data_in = 32'hFFFF_FFFF;
    do_exc("sys_vector", 5'd8, 32'h0000_3000, 1'b0, 32'h0, 32'h8000_0180);
    bus.we = 1'b0;
    rd("sys_cause", 5'd13, 32'h0000_0320);
    rd("sys_epc", 5'd14, 32'h0000_3000);
    rd("sys_status", 5'd12, 32'h0000_0103);

    // BEV=1 vector, exception in a delay slot
    mtc0(5'd12, 32'h0040_0000);
    do_exc("bev_vector", 5'd10, 32'h0000_6004, 1'b1, 32'h0, 32'hBFC0_0380);
    rd("ri_epc_bd", 5'd14, 32'h0000_6000);
    rd("ri_cause", 5'd13, 32'h8000_0028, 32'h8000_007C);

    repeat (3) @(posedge clk);
    #1;
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("ev_q_drained", 32'(ev_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cp0_timer_exc.md
# cp0_timer_exc

Parametrised coprocessor-0 for the pipelined MIPS core. It holds Count, Compare, Status, Cause, EPC and BadVAddr, and prioritises pipeline exceptions over interrupts. It also synchronises a configurable number of hardware interrupt lines and adds a prescaled timer. It sits beside the ID/EXE stages: it decodes `mtc0`/`mfc0`/`eret` and hands the fetch stage a redirect vector on every taken event.

## Interface
- `N_HWINT`, default 5: number of hardware interrupt lines (1..5), mapped to IP[2+i].
- `TIMER_DIV`, default 2: Count increments once every `TIMER_DIV` cycles (1..256).
- `EXC_BASE`, default 32'h8000_0000: exception base when Status.BEV=0.
- `SYNC_STAGES`, default 2: synchroniser depth on `int_` lines (1..3).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `we` in 1: `mtc0` write strobe.
- `r_reg` in 5: CP0 register number for both read and write.
- `data_in` in 32: `mtc0` write data.
- `data_out` out 32: combinational `mfc0` read data. Returns 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; any other number returns 0.
- `exc_valid` in 1: the pipeline reports a synchronous exception this cycle.
- `exc_code` in 5: ExcCode for `exc_valid` (8 syscall, 10 RI, 12 Ov, 4/5 AdEL/AdES).
- `exc_pc`, `exc_bd`, `exc_badvaddr` in 32/1/32: faulting PC, branch-delay flag and bad address. `exc_badvaddr` is used only for codes 4/5.
- `int_pc`, `int_bd`, `int_pc_valid` in 32/1/1: restart PC and delay flag offered for an interrupt. `int_pc_valid`=0 while the pipeline is stalled or flushing.
- `eret` in 1: `eret` in ID.
- `int_` in `N_HWINT`: asynchronous hardware interrupt levels.
- `INT` out 1: an interrupt is pending and enabled.
- `exc_take` out 1: an event is taken this cycle (combinational), and the pipeline must flush.
- `exc_vector` out 32: redirect PC, valid while `exc_take` is 1.
- `eret_pc` out 32: EPC, or ErrorEPC-equivalent EPC when ERL=1. Valid with `eret`.
- `STATUS_out`, `CAUSE_out`, `EPC_out` out 32: register contents.

## Operation
- Reset values:
  - Status = 32'h0040_0004 (BEV=1, ERL=1, IE=0, IM=0).
  - Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 32'hFFFF_FFFF.
  - Prescaler = 0, synchronisers = 0.
  - `INT` = 0, `exc_take` = 0.
- Timer:
  - The prescaler counts 0..`TIMER_DIV`-1. Count increments (mod 2^32) when the prescaler wraps.
  - Writing Count loads `data_in` and clears the prescaler.
  - When the incremented Count equals Compare, IP7 is set and stays sticky. Only a write to Compare clears it.
- Hardware interrupts: `int_[i]` passes through `SYNC_STAGES` flops, then sets IP[2+i] as a level (not latched). IP[6:2+`N_HWINT`] read as 0.
- Software interrupts: IP[1:0] are writable via Cause. All other Cause bits are read-only to `mtc0`.
- `INT` = |(IP & IM) & IE & ~EXL & ~ERL.
- Priority in one cycle, highest first: `exc_valid`, then `INT` with `int_pc_valid`, then `eret`.
  - `exc_take` = `exc_valid` | (`INT` & `int_pc_valid`).
  - An `eret` in the same cycle as a taken event is discarded.
- On a taken event:
  - If EXL=0: EPC ← bd ? pc-4 : pc, and Cause.BD ← bd.
  - If EXL=1: EPC and BD are unchanged.
  - ExcCode ← `exc_code`, or 0 for an interrupt. EXL ← 1.
  - BadVAddr ← `exc_badvaddr` for codes 4/5 only.
- `exc_vector`:
  - BEV=1: 32'hBFC0_0380.
  - Otherwise, interrupt with Cause.IV=1: `EXC_BASE`+32'h200.
  - Otherwise: `EXC_BASE`+32'h180.
- On `eret`: if ERL=1, clear ERL; otherwise clear EXL. `eret_pc` = EPC.
- Write conflict: hardware updates win for the fields they touch in the same cycle (EPC, BD, ExcCode, EXL, IP7). An `mtc0` to other fields of the same register still takes effect.

## Timing
- `data_out`, `INT`, `exc_take`, `exc_vector` and `eret_pc` are combinational from registered state and the current inputs.
- All register updates occur at the rising edge that ends the request cycle.
- `mtc0` data is visible on `data_out` and `INT` in the following cycle. There is no internal bypass; hazards are resolved by the pipeline.
- A pin-to-IP latency of `SYNC_STAGES`+1 edges applies, and `INT` rises in that same cycle.
- A Count match sets IP7 at the edge after the matching increment.
- After an event is taken, `INT` is 0 from the next cycle because EXL=1. Back-to-back events are taken in consecutive cycles.
- `rst` overrides everything at the edge, including mid-prescale and mid-event.

## Test plan
- Reset, then clear BEV/ERL via Status=32'h0000_0001:
  - Read 12 → 32'h0000_0001. Read 11 → 32'hFFFF_FFFF. Read 14 → 0.
- `TIMER_DIV`=2, Count←0, Compare←5:
  - IP7 sets 10–11 cycles after the Compare write, and Count reads 5.
  - With IM7=1 and IE=1, `INT`=1.
  - Writing Compare clears IP7.
- Pulse `int_[0]` with IM2=1, IE=1, and `int_pc`=32'h0000_1004, `int_bd`=1, `int_pc_valid`=1:
  - `exc_take`=1 after 3 edges, `exc_vector`=32'h8000_0180.
  - Then EPC=32'h0000_1000, BD=1, ExcCode=0, EXL=1.
- Same cycle, `exc_valid` (code 12, pc 32'h2000) and a pending interrupt:
  - Overflow wins: ExcCode=12, EPC=32'h2000.
  - The interrupt is masked next cycle.
- Nested exception (AdEL, badvaddr 32'h0000_0003) while EXL=1:
  - EPC is unchanged, BadVAddr=32'h0000_0003, ExcCode=4.
  - Then `eret` → EXL=0 and `eret_pc`=the original EPC.
- `mtc0` Cause=32'hFFFF_FFFF in the same cycle as a syscall (code 8, pc 32'h3000):
  - Cause reads IP[1:0]=2'b11, ExcCode=8, and the remaining fields come from hardware.
